// File: rtl/lib_voq_pkg.sv
// Shared helpers for the VOQ requester and its allocator partner.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package lib_voq_pkg;

  // Classification of a grant column as seen by one requester.
  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_MULTIHOT  = 2'd1;
  localparam logic [1:0] ERR_EMPTY_VOQ = 2'd2;

  // Grant vectors are checked through a fixed 32-bit view, so M may not exceed this.
  localparam int ONEHOT_MAX_W = 32;

  // Read/write pointer width for a queue of the given depth.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Index width for selecting one of n queues/outputs.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  // True when more than one bit is set.
  function automatic logic is_multihot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v & (v - 32'd1)) != '0;
  endfunction

endpackage

// File: rtl/lib_voq_fifo.sv
// Single virtual output queue: circular buffer with occupancy counter.
// Latency: head_data is the current head combinationally; push visible next cycle.
// Backpressure: none internally; caller must not push when full unless popping the same cycle.
module lib_voq_fifo
  import lib_voq_pkg::*;
#(
  parameter int D = 8,
  parameter int W = 32,
  localparam int PW = ptr_width(D),
  localparam int CW = cnt_width(D)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Flit storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap D-1 -> 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(D - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(D - 1)) ? '0 : rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // When full with push and pop together, wr_ptr == rd_ptr: the head read here
  // still sees the old flit because the write lands at the clock edge.
  assign head_data = mem[rd_ptr];
  assign full      = (count == CW'(D));
  assign empty     = (count == '0);

endmodule

// File: rtl/lib_voq_requester.sv
// Allocator requester: M VOQs, request vector out, grant column in, granted head flit out.
// Latency: legal grant -> o_data/o_dest/o_valid one cycle later; illegal grant -> o_error next cycle.
// Backpressure: o_ready per destination VOQ; no downstream stall. Option macro LIB_VOQ_REQUESTER_REG_REQ_EN registers o_request.
module lib_voq_requester
  import lib_voq_pkg::*;
#(
  parameter int M = 4,
  parameter int D = 8,
  parameter int W = 32,
  localparam int DW = idx_width(M),
  localparam int CW = cnt_width(D)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  i_data,
  input  logic [DW-1:0] i_dest,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [M-1:0]  o_request,
  input  logic [M-1:0]  i_grant,
  output logic [W-1:0]  o_data,
  output logic [DW-1:0] o_dest,
  output logic          o_valid,
  output logic          o_error
);

  logic [M-1:0]         push_vec;
  logic [M-1:0]         pop_vec;
  logic [M-1:0]         full_vec;
  logic [M-1:0]         empty_vec;
  logic [M-1:0][CW-1:0] cnt;
  logic [M-1:0][W-1:0]  head;

  logic                 grant_legal;
  logic [1:0]           err_code;
  logic [W-1:0]         sel_data;
  logic [DW-1:0]        sel_idx;

  for (genvar j = 0; j < M; j++) begin : g_voq
    lib_voq_fifo #(
      .D(D),
      .W(W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_vec[j]),
      .push_data (i_data),
      .pop       (pop_vec[j]),
      .head_data (head[j]),
      .count     (cnt[j]),
      .full      (full_vec[j]),
      .empty     (empty_vec[j])
    );
  end

  // Grant validation: one-hot to a non-empty VOQ pops it, anything else nonzero is an error.
  always_comb begin
    grant_legal = 1'b0;
    err_code    = ERR_NONE;
    if (is_multihot(ONEHOT_MAX_W'(i_grant))) begin
      err_code = ERR_MULTIHOT;
    end else if (is_onehot(ONEHOT_MAX_W'(i_grant))) begin
      if ((i_grant & ~empty_vec) != '0) begin
        grant_legal = 1'b1;
      end else begin
        err_code = ERR_EMPTY_VOQ;
      end
    end
    pop_vec = grant_legal ? i_grant : '0;
  end

  // Head flit and index of the granted VOQ; only consumed when the grant is legal.
  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int j = 0; j < M; j++) begin
      if (i_grant[j]) begin
        sel_data = head[j];
        sel_idx  = DW'(j);
      end
    end
  end

  // A full VOQ still accepts when it is being drained in the same cycle.
  assign o_ready = ~full_vec[i_dest] | pop_vec[i_dest];

  // Destination decode: write strobe for the addressed VOQ only when accepted.
  always_comb begin
    push_vec = '0;
    for (int j = 0; j < M; j++) begin
      push_vec[j] = i_valid & o_ready & (i_dest == DW'(j));
    end
  end

  // Output register toward the crossbar; o_data/o_dest hold when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_dest  <= '0;
      o_error <= 1'b0;
    end else begin
      o_valid <= grant_legal;
      o_error <= (err_code != ERR_NONE);
      if (grant_legal) begin
        o_data <= sel_data;
        o_dest <= sel_idx;
      end
    end
  end

`ifdef LIB_VOQ_REQUESTER_REG_REQ_EN
  logic [M-1:0][CW-1:0] next_cnt;

  // Occupancy after this cycle's push/pop, so the registered request tracks count exactly.
  always_comb begin
    next_cnt = '0;
    for (int j = 0; j < M; j++) begin
      next_cnt[j] = cnt[j] + CW'(push_vec[j]) - CW'(pop_vec[j]);
    end
  end

  // Registered request vector, cutting the combinational path into the allocator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_request <= '0;
    end else begin
      for (int j = 0; j < M; j++) begin
        o_request[j] <= (next_cnt[j] != '0);
      end
    end
  end
`else
  // Combinational request: one bit per non-empty VOQ.
  always_comb begin
    o_request = '0;
    for (int j = 0; j < M; j++) begin
      o_request[j] = (cnt[j] != '0);
    end
  end
`endif

endmodule

// File: doc/lib_voq_requester.md
Name: lib_voq_requester

Overview:
- Requester-side partner of the NxM input-first separable allocator: one instance per allocator input.
- Buffers incoming flits in M virtual output queues (VOQs), one per destination, to avoid head-of-line blocking.
- Drives the allocator with a per-output request vector and consumes that input's grant column.
- Dequeues and forwards the head flit of the granted VOQ.

Parameters:
- M, 4, number of outputs/VOQs (≥2)
- D, 8, depth of each VOQ in flits (power of 2, ≥2)
- W, 32, flit data width in bits

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- i_data  input  W  incoming flit
- i_dest  input  clog2(M)  destination VOQ index of i_data
- i_valid  input  1  i_data/i_dest valid this cycle
- o_ready  output  1  VOQ[i_dest] can accept; write occurs when i_valid & o_ready
- o_request  output  M  bit j set = VOQ j non-empty; to allocator row for this input
- i_grant  input  M  this input's grant column from allocator, one-hot or zero
- o_data  output  W  dequeued flit
- o_dest  output  clog2(M)  index of granted VOQ
- o_valid  output  1  o_data/o_dest valid
- o_error  output  1  one-cycle pulse on illegal grant

Behaviour:
- Reset (async assert, sync-safe deassert): all VOQs empty; o_request=0, o_valid=0, o_data=0, o_dest=0, o_error=0. o_ready=1 after reset.
- Each VOQ is a circular buffer: rd/wr pointers of clog2(D) bits plus an occupancy counter of clog2(D)+1 bits. Pointers wrap D-1 to 0.
- o_ready is combinational: (count[i_dest] != D) OR (VOQ i_dest popped this cycle).
  - Full-queue write is allowed when the same VOQ is popped in the same cycle.
  - A write with i_valid & ~o_ready is dropped; the upstream must hold the flit.
- o_request[j] is combinational: count[j] != 0.
- Legal grant: i_grant one-hot at bit j with count[j] != 0.
  - That cycle: VOQ j popped, rd pointer j advances.
  - Next cycle: o_data = head flit, o_dest = j, o_valid = 1.
  - Latency grant->o_valid is 1 cycle. There is no downstream backpressure; the crossbar always accepts.
- o_valid=0 in any cycle following no legal grant; o_data holds its last value.
- Illegal grant (multi-hot, or one-hot to an empty VOQ): no pop, no state change, o_error=1 in the next cycle.
- i_grant=0: no action, o_error stays 0.
- Simultaneous write and pop, same VOQ:
  - count unchanged, both pointers advance.
  - If the VOQ was empty, no pop can occur; the write completes and the request rises next cycle.
- No write-to-read bypass: a flit written at cycle t can be requested at t+1 and granted at t+1 at the earliest.
- Reset mid-operation: all queued flits are discarded, o_valid drops immediately (async).

Optional Feature:
- Macro: LIB_VOQ_REQUESTER_REG_REQ_EN.
- Defined:
  - o_request is registered: o_request[j] <= next_count[j] != 0, where next_count includes this cycle's push and pop.
  - Breaks the combinational path into the allocator; the request/count relationship stays consistent cycle by cycle.
  - Reset value 0.
- Undefined: o_request is combinational as above.
- Grant/pop rules identical in both builds.

Decomposition:
- Package lib_voq_pkg:
  - pointer/count width helper functions (clog2-based)
  - onehot-check function shared with the allocator bench
  - error-code constants
- Sub-module lib_voq_fifo: single-VOQ circular buffer (push, pop, data out, count, full, empty), instantiated M times via generate.
- Top-level logic: destination decode, grant validation, output register.

Test Plan:
- Reset then idle: o_request=0000, o_ready=1, o_valid=0, o_error=0 for 10 cycles.
- Write flits 0xA0,0xA1 to dest 2, then grant 0100 twice in consecutive cycles -> o_request=0100 until drained; o_data=0xA0 then 0xA1 with o_dest=2, one cycle after each grant; o_request=0000 after the second pop.
- Fill VOQ 1 with 8 flits -> o_ready=0 for i_dest=1, o_ready=1 for i_dest=0. Then push dest 1 while granting 0010 in the same cycle -> write accepted, count stays 8.
- Grant 1000 with VOQ 3 empty, then grant 0011 with VOQs 0 and 1 non-empty -> o_error pulses after each, no o_valid, counts unchanged.
- Interleave writes to dests 0,1,2,3 and round-robin grants over 200 random cycles -> per-dest output order matches input order, no loss or duplication (scoreboard).
- Assert reset with 5 flits queued, release -> o_request=0000, o_valid=0 immediately; a subsequent write and grant work normally. Repeat with LIB_VOQ_REQUESTER_REG_REQ_EN defined: o_request rises one cycle after first write.
